// File: rtl/cpu_handshake_tx.sv
// cpu_handshake_tx: DATA_W-bit four-phase send/ack transmitter fed by a DEPTH-entry FIFO.
// Define ACK_TIMEOUT_EN to abort a transfer after TIMEOUT ack-less SEND cycles (sticky err).
module cpu_handshake_tx #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   ack,
    output logic                   send,
    output logic [DATA_W-1:0]      data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       tx_count,
    output logic                   err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEND    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("cpu_handshake_tx: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                send_q, send_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    tx_count_q, tx_count_d;
    logic                push_s;
    logic                pop_s;
    logic                done_s;
    logic                to_hit_s;

`ifdef ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                err_q, err_d;

    // The counter hits TIMEOUT on this edge; a simultaneous ack still wins in the FSM.
    assign to_hit_s = (state_q == ST_SEND) && !ack && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Timeout counter is zero outside SEND, so entering SEND always starts from zero.
    always_comb begin
        to_cnt_d = {TO_W{1'b0}};
        if (state_q == ST_SEND && !ack) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
        err_d = err_q | to_hit_s;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= {TO_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign to_hit_s = 1'b0;
    assign err      = 1'b0;
`endif

    // Handshake FSM: decides the next state and when the head word leaves the FIFO.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !ack) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (ack) begin
                    state_d = ST_RELEASE;
                    pop_s   = 1'b1;
                    done_s  = 1'b1;
                end else if (to_hit_s) begin
                    state_d = ST_RELEASE;
                    pop_s   = 1'b1;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_RELEASE: begin
                if (!ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping, transfer counter and next-cycle Moore outputs.
    always_comb begin
        push_s     = wr_en && !full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        tx_count_d = tx_count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (done_s) begin
            tx_count_d = tx_count_q + CNT_W'(1);
        end else begin
            tx_count_d = tx_count_q;
        end
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == {LVL_W{1'b0}});
        // Head is stable while in SEND: pops only happen on the edge that leaves SEND.
        if (state_d == ST_SEND) begin
            send_d = 1'b1;
            data_d = mem_q[rd_ptr_q];
        end else begin
            send_d = 1'b0;
            data_d = {DATA_W{1'b0}};
        end
    end

    // State, FIFO pointers/flags, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_count_q <= {CNT_W{1'b0}};
            send_q     <= 1'b0;
            data_q     <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_count_q <= tx_count_d;
            send_q     <= send_d;
            data_q     <= data_d;
        end
    end

    // FIFO storage; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign send     = send_q;
    assign data     = data_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_cpu_handshake_tx.sv
// Self-checking bench for cpu_handshake_tx: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based protocol model.
module tb_cpu_handshake_tx;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              ack;
    logic              send;
    logic [DATA_W-1:0] data;
    logic              full;
    logic              empty;
    logic [2:0]        level;
    logic [CNT_W-1:0]  tx_count;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_handshake_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .ack     (ack),
        .send    (send),
        .data    (data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_count(tx_count),
        .err     (err)
    );

    // Reference model: a word queue plus "requesting"/"releasing" flags.
    logic [DATA_W-1:0] mq[$];
    bit                m_req;
    bit                m_rel;
    int                m_age;
    logic [CNT_W-1:0]  m_tx;
    bit                m_err;

    function automatic void model_step(bit r, bit we, logic [DATA_W-1:0] wd, bit a);
        int occ;
        if (r) begin
            mq.delete();
            m_req = 1'b0;
            m_rel = 1'b0;
            m_age = 0;
            m_tx  = '0;
            m_err = 1'b0;
            return;
        end
        occ = mq.size();
        if (m_req) begin
            if (a) begin
                void'(mq.pop_front());
                m_tx  = m_tx + 1'b1;
                m_req = 1'b0;
                m_rel = 1'b1;
            end else begin
                m_age = m_age + 1;
`ifdef ACK_TIMEOUT_EN
                if (m_age == TIMEOUT) begin
                    void'(mq.pop_front());
                    m_err = 1'b1;
                    m_req = 1'b0;
                    m_rel = 1'b1;
                end
`endif
            end
        end else if (m_rel) begin
            if (!a) m_rel = 1'b0;
        end else if (occ > 0 && !a) begin
            m_req = 1'b1;
            m_age = 0;
        end
        if (we && occ < DEPTH) mq.push_back(wd);
    endfunction

    task automatic tick();
        model_step(rst, wr_en, wr_data, ack);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string tag, bit e_send, logic [DATA_W-1:0] e_data, int e_lvl,
                           int e_tx, bit e_err);
        chk({tag, " send"},  32'(send),     32'(e_send));
        chk({tag, " data"},  32'(data),     32'(e_data));
        chk({tag, " level"}, 32'(level),    32'(e_lvl));
        chk({tag, " full"},  32'(full),     32'(e_lvl == DEPTH));
        chk({tag, " empty"}, 32'(empty),    32'(e_lvl == 0));
        chk({tag, " tx"},    32'(tx_count), 32'(e_tx));
        chk({tag, " err"},   32'(err),      32'(e_err));
    endtask

    task automatic chk_model(string tag);
        chk_out(tag, m_req, m_req ? mq[0] : '0, mq.size(), int'(m_tx), m_err);
    endtask

    typedef struct {
        bit                r;
        bit                we;
        logic [DATA_W-1:0] wd;
        bit                a;
        bit                e_send;
        logic [DATA_W-1:0] e_data;
        int                e_lvl;
        int                e_tx;
    } vec_t;

    vec_t tv[$];

    task automatic add(bit r, bit we, logic [DATA_W-1:0] wd, bit a,
                       bit es, logic [DATA_W-1:0] ed, int el, int et);
        vec_t v;
        v.r = r; v.we = we; v.wd = wd; v.a = a;
        v.e_send = es; v.e_data = ed; v.e_lvl = el; v.e_tx = et;
        tv.push_back(v);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; ack = 1'b0;

        // Reset, idle, single word A5 (ack 2 cycles after send, drop 1 cycle after send falls).
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
        add(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1, 0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1, 0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1, 0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1);
        // Fill with 01..05 while ack is low: 05 is dropped, then drain 01..04.
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0);
        add(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1, 0);
        add(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 2, 0);
        add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3, 0);
        add(1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 4, 0);
        add(1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 4, 0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3, 1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3, 1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 3, 1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2, 2);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2, 2);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 2, 2);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 3);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1, 3);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1, 3);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 4);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 4);

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].r; wr_en = tv[i].we; wr_data = tv[i].wd; ack = tv[i].a;
            tick();
            chk_out($sformatf("row%0d", i), tv[i].e_send, tv[i].e_data, tv[i].e_lvl,
                    tv[i].e_tx, 1'b0);
        end

        // Stale ack in IDLE blocks a queued word until ack drops.
        wr_en = 1'b1; wr_data = 8'h3C; ack = 1'b1;
        tick(); chk_out("stale0", 1'b0, 8'h00, 1, 4, 1'b0);
        wr_en = 1'b0;
        tick(); chk_out("stale1", 1'b0, 8'h00, 1, 4, 1'b0);
        tick(); chk_out("stale2", 1'b0, 8'h00, 1, 4, 1'b0);
        ack = 1'b0;
        tick(); chk_out("stale3", 1'b1, 8'h3C, 1, 4, 1'b0);
        ack = 1'b1;
        tick(); chk_out("stale4", 1'b0, 8'h00, 0, 5, 1'b0);
        ack = 1'b0;
        tick(); chk_out("stale5", 1'b0, 8'h00, 0, 5, 1'b0);

        // Reset while in SEND with 3 words queued (ack high on the reset edge too).
        rst = 1'b1; tick(); rst = 1'b0;
        wr_en = 1'b1; wr_data = 8'hA1; tick(); chk_out("mrst0", 1'b0, 8'h00, 1, 0, 1'b0);
        wr_data = 8'hA2;             tick(); chk_out("mrst1", 1'b1, 8'hA1, 2, 0, 1'b0);
        wr_data = 8'hA3;             tick(); chk_out("mrst2", 1'b1, 8'hA1, 3, 0, 1'b0);
        wr_en = 1'b0; rst = 1'b1; ack = 1'b1;
        tick(); chk_out("mrst3", 1'b0, 8'h00, 0, 0, 1'b0);
        rst = 1'b0; ack = 1'b0;
        tick(); chk_out("mrst4", 1'b0, 8'h00, 0, 0, 1'b0);

`ifdef ACK_TIMEOUT_EN
        // First word never acked: aborted after TIMEOUT SEND cycles; second completes.
        wr_en = 1'b1; wr_data = 8'h11; tick(); chk_out("to_a", 1'b0, 8'h00, 1, 0, 1'b0);
        wr_data = 8'h22;               tick(); chk_out("to_b", 1'b1, 8'h11, 2, 0, 1'b0);
        wr_en = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick(); chk_out($sformatf("to_wait%0d", k), 1'b1, 8'h11, 2, 0, 1'b0);
        end
        tick(); chk_out("to_hit", 1'b0, 8'h00, 1, 0, 1'b1);
        tick(); chk_out("to_rel", 1'b0, 8'h00, 1, 0, 1'b1);
        tick(); chk_out("to_w2",  1'b1, 8'h22, 1, 0, 1'b1);
        ack = 1'b1;
        tick(); chk_out("to_ok",  1'b0, 8'h00, 0, 1, 1'b1);
        ack = 1'b0;
        tick(); chk_out("to_end", 1'b0, 8'h00, 0, 1, 1'b1);
`endif

        // Randomized traffic against the model, with occasional resets.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < 500; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_data = 8'($urandom);
            if (send) ack = ($urandom_range(0, 3) != 0);
            else      ack = ($urandom_range(0, 4) == 0);
            tick();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
